// File: rtl/pcd8544_pkg.sv
// Shared geometry, opcode table and reset state for the PCD8544 responder.
// Opcodes are mask/value pairs matched against a received command byte.
package pcd8544_pkg;
  localparam int COLS = 84;
  localparam int BANKS = 6;
  localparam int RAM_DEPTH = 504;
  localparam int SYNC_STAGES = 2;

  typedef struct packed {
    logic [7:0] mask;
    logic [7:0] value;
  } opcode_t;

  localparam opcode_t FUNC_SET = '{8'hF8, 8'h20};
  localparam opcode_t DISP_CTL = '{8'hFA, 8'h08};
  localparam opcode_t SET_Y    = '{8'hF8, 8'h40};
  localparam opcode_t SET_X    = '{8'h80, 8'h80};
  localparam opcode_t SET_VOP  = '{8'h80, 8'h80};
  localparam opcode_t SET_BIAS = '{8'hF8, 8'h10};
  localparam opcode_t SET_TC   = '{8'hFC, 8'h04};

  typedef struct packed {
    logic       h;
    logic       v;
    logic       pd;
    logic [1:0] disp;
    logic [6:0] vop;
    logic [2:0] bias;
    logic [1:0] tc;
    logic [6:0] x;
    logic [2:0] y;
  } lcd_state_t;

  localparam lcd_state_t STATE_RST = '{
    h: 1'b0, v: 1'b0, pd: 1'b1, disp: 2'b00,
    vop: 7'd0, bias: 3'd0, tc: 2'd0,
    x: 7'd0, y: 3'd0
  };

  function automatic logic op_match(
    input logic [7:0] b,
    input opcode_t    op
  );
    return (b & op.mask) == op.value;
  endfunction
endpackage

// File: rtl/pcd8544_spi_if.sv
// SPI/LCD control lines between spi_master and the PCD8544 responder.
// The master drives every line; the responder only samples them.
interface pcd8544_spi_if;
  logic sclk;
  logic mosi;
  logic sce;
  logic dc;
  logic lcd_rst;

  modport master (output sclk, mosi, sce, dc, lcd_rst);
  modport slave  (input  sclk, mosi, sce, dc, lcd_rst);
endinterface

// File: rtl/pcd8544_ram.sv
// Display RAM: one write port, one registered read port.
// A same-address read and write returns the old contents.
module pcd8544_ram
  import pcd8544_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we,
  input  logic [8:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/pcd8544_spi_responder.sv
// PCD8544 LCD controller model: SPI byte receiver, instruction
// decoder, X/Y address pointers and the 504-byte display RAM.
module pcd8544_spi_responder
  import pcd8544_pkg::*;
#(
  parameter int COLS = pcd8544_pkg::COLS,
  parameter int BANKS = pcd8544_pkg::BANKS,
  parameter int SYNC_STAGES = pcd8544_pkg::SYNC_STAGES
) (
  input  logic         clk,
  input  logic         reset,
  pcd8544_spi_if.slave spi,
  output logic         byte_valid,
  output logic [7:0]   byte_out,
  output logic         byte_is_data,
  output logic [6:0]   x_addr,
  output logic [2:0]   y_addr,
  output logic         h_mode,
  output logic         v_mode,
  output logic         power_down,
  output logic [1:0]   disp_mode,
  output logic [6:0]   vop,
  output logic [2:0]   bias,
  output logic [1:0]   tc,
  output logic         frame_wrap,
  output logic         addr_err,
  input  logic [8:0]   rd_addr,
  output logic [7:0]   rd_data
);
  localparam logic [6:0] X_LAST = 7'(COLS - 1);
  localparam logic [2:0] Y_LAST = 3'(BANKS - 1);
  localparam logic [7:0] X_LIM = 8'(COLS);
  localparam logic [3:0] Y_LIM = 4'(BANKS);
  localparam logic [8:0] ROW_W = 9'(COLS);
  // {sclk, mosi, sce, dc, lcd_rst} with the bus idle
  localparam logic [4:0] IDLE = 5'b00101;

  logic [4:0] sync_q [SYNC_STAGES];
  logic       sclk_s, mosi_s, sce_s, dc_s, rst_n_s;
  logic       sclk_d;
  logic       rise;

  assign {sclk_s, mosi_s, sce_s, dc_s, rst_n_s} =
    sync_q[SYNC_STAGES-1];
  assign rise = sclk_s & ~sclk_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE;
      sclk_d <= 1'b0;
    end else begin
      sync_q[0] <= {spi.sclk, spi.mosi, spi.sce, spi.dc, spi.lcd_rst};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sclk_d <= sclk_s;
    end
  end

  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       bv_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt      <= '0;
      shreg        <= '0;
      bv_q         <= 1'b0;
      byte_out     <= '0;
      byte_is_data <= 1'b0;
    end else begin
      bv_q <= 1'b0;
      if (!rst_n_s) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (sce_s) begin
        bit_cnt <= '0;
      end else if (rise) begin
        shreg   <= {shreg[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          bv_q         <= 1'b1;
          byte_out     <= {shreg, mosi_s};
          byte_is_data <= dc_s;
        end
      end
    end
  end

  assign byte_valid = bv_q & rst_n_s;

  lcd_state_t st_q, st_d;
  logic       wrap_d, err_d;
  logic [8:0] wr_addr;
  logic       we;

  assign wr_addr = {6'd0, st_q.y} * ROW_W + {2'd0, st_q.x};
  assign we = byte_valid & byte_is_data;

  always_comb begin
    st_d   = st_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (we) begin
      if (!st_q.v) begin
        st_d.x = (st_q.x == X_LAST) ? '0 : st_q.x + 7'd1;
        if (st_q.x == X_LAST) begin
          st_d.y = (st_q.y == Y_LAST) ? '0 : st_q.y + 3'd1;
          wrap_d = (st_q.y == Y_LAST);
        end
      end else begin
        st_d.y = (st_q.y == Y_LAST) ? '0 : st_q.y + 3'd1;
        if (st_q.y == Y_LAST) begin
          st_d.x = (st_q.x == X_LAST) ? '0 : st_q.x + 7'd1;
          wrap_d = (st_q.x == X_LAST);
        end
      end
    end else if (byte_valid) begin
      unique case (1'b1)
        op_match(byte_out, FUNC_SET):
          {st_d.pd, st_d.v, st_d.h} = byte_out[2:0];
        !st_q.h && op_match(byte_out, DISP_CTL):
          st_d.disp = {byte_out[2], byte_out[0]};
        !st_q.h && op_match(byte_out, SET_Y): begin
          if ({1'b0, byte_out[2:0]} < Y_LIM) st_d.y = byte_out[2:0];
          else err_d = 1'b1;
        end
        !st_q.h && op_match(byte_out, SET_X): begin
          if ({1'b0, byte_out[6:0]} < X_LIM) st_d.x = byte_out[6:0];
          else err_d = 1'b1;
        end
        st_q.h && op_match(byte_out, SET_VOP):
          st_d.vop = byte_out[6:0];
        st_q.h && op_match(byte_out, SET_BIAS):
          st_d.bias = byte_out[2:0];
        st_q.h && op_match(byte_out, SET_TC):
          st_d.tc = byte_out[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= STATE_RST;
      frame_wrap <= 1'b0;
      addr_err   <= 1'b0;
    end else if (!rst_n_s) begin
      st_q       <= STATE_RST;
      frame_wrap <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      st_q       <= st_d;
      frame_wrap <= wrap_d;
      addr_err   <= err_d;
    end
  end

  assign x_addr     = st_q.x;
  assign y_addr     = st_q.y;
  assign h_mode     = st_q.h;
  assign v_mode     = st_q.v;
  assign power_down = st_q.pd;
  assign disp_mode  = st_q.disp;
  assign vop        = st_q.vop;
  assign bias       = st_q.bias;
  assign tc         = st_q.tc;

  pcd8544_ram #(
    .DEPTH(COLS * BANKS)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (byte_out),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
endmodule
